// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the requester A/B handshakes, the clear control and
// the RAM-side signals of ram_arbiter.
//   Requesters : req_x, we_x, addr_x[3:0], wdata_x[7:0] -> gnt_x, rvalid_x, rdata_x[7:0]
//   Clear      : clear_start -> busy, clear_done
//   RAM        : ram_we, ram_addr[3:0], ram_wdata[7:0] out, ram_rdata[7:0] in
// slave = arbiter view, master = requesters/RAM view.
interface ram_arbiter_if;
  logic       req_a, req_b;
  logic       we_a, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b;
  logic       rvalid_a, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       clear_start;
  logic       busy;
  logic       clear_done;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  clear_start, ram_rdata,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
    output busy, clear_done, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output clear_start, ram_rdata,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
    input  busy, clear_done, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter plus zero-fill sequencer in front
// of a 16x8 single-port RAM with registered read data.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : ram_arbiter_if.slave (requesters, clear control, RAM side)
module ram_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  ram_arbiter_if.slave bus
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  port_e      last_q, last_d;
  logic       rvalid_a_q, rvalid_b_q;
  logic       done_q;

  logic       gnt_a, gnt_b;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      ST_ARB: begin
        // Grants are suppressed under reset; a clear write in flight at the
        // reset edge is left alone since it is driven from ST_CLEAR.
        if (reset_n) begin
          if (bus.req_a && (!bus.req_b || last_q == PORT_B)) gnt_a = 1'b1;
          else if (bus.req_b)                                gnt_b = 1'b1;
        end
        if (gnt_a) begin
          ram_we    = bus.we_a;
          ram_addr  = bus.addr_a;
          ram_wdata = bus.wdata_a;
          last_d    = PORT_A;
        end else if (gnt_b) begin
          ram_we    = bus.we_b;
          ram_addr  = bus.addr_b;
          ram_wdata = bus.wdata_b;
          last_d    = PORT_B;
        end
        if (bus.clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'hF) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_ARB;
      cnt_q      <= '0;
      last_q     <= PORT_B;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rvalid_a_q <= gnt_a & ~bus.we_a;
      rvalid_b_q <= gnt_b & ~bus.we_b;
      done_q     <= (state_q == ST_CLEAR) && (cnt_q == 4'hF);
    end
  end

  assign bus.gnt_a      = gnt_a;
  assign bus.gnt_b      = gnt_b;
  assign bus.rvalid_a   = rvalid_a_q;
  assign bus.rvalid_b   = rvalid_b_q;
  assign bus.rdata_a    = rvalid_a_q ? bus.ram_rdata : '0;
  assign bus.rdata_b    = rvalid_b_q ? bus.ram_rdata : '0;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.clear_done = done_q;
  assign bus.ram_we     = ram_we;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a read-data scoreboard for ram_arbiter,
// including a behavioural 16x8 RAM with one-cycle registered read.
module tb_ram_arbiter;

  logic clk;
  logic reset_n;
  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [7:0]  d;
    int unsigned c;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned done_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expected read data whenever the DUT presents rvalid
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (bus.clear_done) done_cnt++;
      if (bus.rvalid_a) begin
        if (qa.size() == 0) chk("rvalid_a_unexpected", 1, 0);
        else begin
          e = qa.pop_front();
          chk("rdata_a", {24'h0, bus.rdata_a}, {24'h0, e.d});
          chk("rvalid_a_cycle", cyc, e.c);
        end
      end else chk("rdata_a_idle", {24'h0, bus.rdata_a}, 0);
      if (bus.rvalid_b) begin
        if (qb.size() == 0) chk("rvalid_b_unexpected", 1, 0);
        else begin
          e = qb.pop_front();
          chk("rdata_b", {24'h0, bus.rdata_b}, {24'h0, e.d});
          chk("rvalid_b_cycle", cyc, e.c);
        end
      end else chk("rdata_b_idle", {24'h0, bus.rdata_b}, 0);
      chk("gnt_mutex", {31'h0, bus.gnt_a & bus.gnt_b}, 0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transaction on port A (pb=0) or B (pb=1); read data expectation is
  // pushed when the grant is seen.
  task automatic access(input bit pb, input logic we, input logic [3:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_d);
    int   n;
    logic g;
    exp_t e;
    if (!pb) begin
      bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd;
    end else begin
      bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd;
    end
    n = 0;
    @(negedge clk);
    g = pb ? bus.gnt_b : bus.gnt_a;
    while (!g && n < 32) begin
      @(negedge clk);
      g = pb ? bus.gnt_b : bus.gnt_a;
      n++;
    end
    chk("grant_wait", {31'h0, g}, 1);
    if (g && !we) begin
      e.d = exp_d;
      e.c = cyc + 1;
      if (!pb) qa.push_back(e);
      else     qb.push_back(e);
    end
    next_cycle();
    if (!pb) bus.req_a = 1'b0;
    else     bus.req_b = 1'b0;
  endtask

  task automatic fill_ff();
    for (int i = 0; i < 16; i++) access(0, 1'b1, 4'(i), 8'hFF, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   nb;
    int unsigned done0;

    // Reset with random inputs
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      {bus.req_a, bus.req_b, bus.we_a, bus.we_b, bus.clear_start} = 5'($urandom);
      bus.addr_a = 4'($urandom); bus.addr_b = 4'($urandom);
      bus.wdata_a = 8'($urandom); bus.wdata_b = 8'($urandom);
      if (k == 0) next_cycle();
    end
    @(negedge clk);
    chk("rst_gnt", {30'h0, bus.gnt_a, bus.gnt_b}, 0);
    chk("rst_rvalid", {30'h0, bus.rvalid_a, bus.rvalid_b}, 0);
    chk("rst_rdata", {16'h0, bus.rdata_a, bus.rdata_b}, 0);
    chk("rst_busy_done", {30'h0, bus.busy, bus.clear_done}, 0);
    chk("rst_ram", {19'h0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);
    next_cycle();
    {bus.req_a, bus.req_b, bus.we_a, bus.we_b, bus.clear_start} = '0;
    bus.addr_a = '0; bus.addr_b = '0; bus.wdata_a = '0; bus.wdata_b = '0;
    reset_n = 1'b1;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 4'h0; bus.wdata_a = 8'h11;
    @(negedge clk);
    chk("post_rst_gnt_a", {31'h0, bus.gnt_a}, 1);
    chk("post_rst_ram", {19'h0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {19'h0, 1'b1, 4'h0, 8'h11});
    next_cycle();
    bus.req_a = 1'b0;

    // Write then read
    access(0, 1'b1, 4'h3, 8'hA5, 8'h00);
    access(0, 1'b0, 4'h3, 8'h00, 8'hA5);
    @(negedge clk);
    chk("wr_rd_rvalid", {30'h0, bus.rvalid_a, bus.rvalid_b}, {30'h0, 2'b10});
    next_cycle();

    // Contention: B preloads addr 5 (leaves last=B), then A/B alternate
    access(1, 1'b1, 4'h5, 8'h3C, 8'h00);
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'h3;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 4'h5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt", {30'h0, bus.gnt_a, bus.gnt_b}, (k % 2 == 0) ? 32'd2 : 32'd1);
      e.c = cyc + 1;
      if (k % 2 == 0) begin e.d = 8'hA5; qa.push_back(e); end
      else            begin e.d = 8'h3C; qb.push_back(e); end
      next_cycle();
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    next_cycle();

    // Clear with req_a held high
    fill_ff();
    done0 = done_cnt;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 4'h0; bus.clear_start = 1'b1;
    @(negedge clk);
    chk("clr_c0_gnt_a", {31'h0, bus.gnt_a}, 1);
    e.d = 8'hFF; e.c = cyc + 1; qa.push_back(e);
    next_cycle();
    bus.clear_start = 1'b0; bus.addr_a = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("clr_busy", {31'h0, bus.busy}, 1);
      chk("clr_gnt_a", {31'h0, bus.gnt_a}, 0);
      chk("clr_done_early", {31'h0, bus.clear_done}, 0);
      chk("clr_ram", {19'h0, bus.ram_we, bus.ram_addr, bus.ram_wdata}, {19'h0, 1'b1, 4'(k), 8'h00});
      next_cycle();
    end
    @(negedge clk);
    chk("clr_done_c17", {30'h0, bus.clear_done, bus.busy}, {30'h0, 2'b10});
    chk("clr_gnt_a_c17", {31'h0, bus.gnt_a}, 1);
    e.d = 8'h00; e.c = cyc + 1; qa.push_back(e);
    next_cycle();
    bus.req_a = 1'b0;
    access(0, 1'b0, 4'h0, 8'h00, 8'h00);
    next_cycle();
    chk("clr_done_count", done_cnt - done0, 1);

    // Reset in the middle of a clear
    fill_ff();
    done0 = done_cnt;
    bus.clear_start = 1'b1;
    next_cycle();
    bus.clear_start = 1'b0;
    repeat (7) next_cycle();
    @(negedge clk);
    chk("mid_cnt7", {27'h0, bus.busy, bus.ram_addr}, {27'h0, 1'b1, 4'h7});
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_busy_after_rst", {31'h0, bus.busy}, 0);
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) access(0, 1'b0, 4'(i), 8'h00, (i < 8) ? 8'h00 : 8'hFF);
    repeat (2) next_cycle();
    chk("mid_no_done", done_cnt - done0, 0);

    // clear_start repeated while busy
    done0 = done_cnt;
    bus.clear_start = 1'b1;
    next_cycle();
    bus.clear_start = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nb++;
      bus.clear_start = (nb == 5);
      next_cycle();
    end
    chk("rep_busy_cycles", nb, 16);
    chk("rep_done_after", {31'h0, bus.clear_done}, 1);
    bus.clear_start = 1'b0;
    repeat (3) next_cycle();
    chk("rep_done_count", done_cnt - done0, 1);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and clear sequencer in front of the 16×8 single-port program/data RAM. It shares the RAM between requester A (control unit / CPU bus) and requester B (program loader / debug port). Arbitration is round-robin with one-cycle transactions. An on-demand sequencer zero-fills all 16 locations. The block drives the RAM's `we`, `address` and `data_in` directly and returns the RAM's registered `data_out` to the granted reader.

## Interface
- No parameters: address width is fixed at 4 bits (16 locations) and data width at 8 bits.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_a`, `req_b` in 1: access request from A / B.
- `we_a`, `we_b` in 1: 1 = write, 0 = read.
- `addr_a`, `addr_b` in 4: target address.
- `wdata_a`, `wdata_b` in 8: write data.
- `gnt_a`, `gnt_b` out 1: combinational grant; the access executes at the next rising edge.
- `rvalid_a`, `rvalid_b` out 1: registered; read data valid this cycle.
- `rdata_a`, `rdata_b` out 8: equal to `ram_rdata` while the matching rvalid is high, else 8'h00.
- `clear_start` in 1: request a full zero-fill.
- `busy` out 1: high while the clear sequence runs.
- `clear_done` out 1: one-cycle pulse after the final clear write.
- `ram_we` out 1, `ram_addr` out 4, `ram_wdata` out 8: drive the RAM write enable, address and write data.
- `ram_rdata` in 8: RAM registered read output, one-cycle latency.

## Operation
- The FSM has two states, ARB and CLEAR. It also holds a 4-bit clear counter `cnt` and a 1-bit `last` pointer recording the last granted port.
- ARB state:
  - With exactly one request, that port is granted.
  - With both requesting, the port ≠ `last` is granted. `last` updates only on a grant.
  - At most one grant per cycle; `gnt_a & gnt_b` is never 1.
- Granted port's effect on the RAM:
  - `ram_addr` = its address.
  - `ram_we` = its we.
  - `ram_wdata` = its wdata.
- With no grant: `ram_we` = 0, `ram_addr` = 4'h0, `ram_wdata` = 8'h00.
- Requesters hold req/we/addr/wdata stable until they sample their grant high. Keeping req high afterwards issues another transaction.
- `clear_start` is sampled at a rising edge in ARB and moves the FSM to CLEAR with `cnt` = 0.
  - The ARB cycle in which `clear_start` is high still arbitrates normally.
  - `clear_start` is ignored while in CLEAR.
- CLEAR state:
  - Outputs: `ram_we` = 1, `ram_addr` = `cnt`, `ram_wdata` = 8'h00, `busy` = 1.
  - Both grants are forced to 0.
  - `cnt` increments each cycle.
  - At `cnt` = 15 the FSM returns to ARB and `clear_done` pulses in the following cycle.
- Pending requests stall during CLEAR and are arbitrated normally on return, with the `last` pointer unchanged.
- Reset values: ARB, `cnt` = 0, `last` = B (A wins the first tie); all grants, rvalids, `busy`, `clear_done` and `ram_we` = 0; all rdata = 8'h00.
- Reset during CLEAR:
  - The clear is aborted and `clear_done` does not pulse.
  - RAM contents are not reset.
  - The write presented at the reset edge still completes, because the RAM has no reset.

## Timing
- A grant in cycle N means the RAM samples the access at the end of N.
- For a read granted in cycle N, `rvalid_x` = 1 in cycle N+1 and `rdata_x` = `ram_rdata` in N+1.
- Writes produce no rvalid.
- Back-to-back grants are allowed, giving a throughput of 1 access per cycle.
- Clear takes exactly 16 cycles with `busy` high. `clear_done` is high in cycle 17, which is also the first cycle a grant is possible again.
- A read granted in the cycle before `clear_start` is sampled still returns its rvalid in the first CLEAR cycle.
- Read-during-write ordering is the RAM's responsibility; the arbiter never overlaps the two.

## Test plan
- **Reset:** hold `reset_n` = 0 for 2 cycles with random inputs → all outputs 0 and `ram_addr` = 0; after release, `req_a` = 1 gives `gnt_a` = 1 in the same cycle.
- **Write then read:** A writes 8'hA5 to addr 3, then A reads addr 3 → `rvalid_a` = 1 one cycle after the read grant, `rdata_a` = 8'hA5, `rvalid_b` = 0.
- **Contention:** `req_a` = `req_b` = 1 for 6 cycles with B reading addr 5 (preloaded 8'h3C) → grants alternate A, B, A, B, A, B; each B grant yields `rvalid_b` = 1 next cycle with `rdata_b` = 8'h3C.
- **Clear:**
  - Stimulus: fill addrs 0–15 with 8'hFF, pulse `clear_start` while `req_a` is held high.
  - Response: `busy` = 1 for 16 cycles, `gnt_a` = 0 throughout, `clear_done` pulses in cycle 17, then `gnt_a` = 1.
  - Check: reads of addrs 0 and 15 return 8'h00.
- **Reset mid-clear:** start a clear on a RAM filled with 8'hFF, drop `reset_n` at `cnt` = 7 → `busy` = 0 the next cycle and no `clear_done`; addrs 0–7 read 8'h00 and addrs 8–15 read 8'hFF.
- **Clear_start while busy:** pulse `clear_start` again at `cnt` = 4 → the sequence still ends after 16 total cycles with exactly one `clear_done`.
